tiny16_bus_arbiter: RTL and testbench
=====================================

Name: tiny16_bus_arbiter

Overview:
Shares the tiny16 system bus between two masters: m0 (CPU) and m1 (program loader/DMA).
- Grants the bus round-robin and latches the winner's request.
- Decodes address[15:14] into memory, port or unmapped regions.
- Drives synchronous memory/port strobes with a programmable wait-state count.
- Returns a one-cycle ack with read data.
- Sits between the CPU/loader and the ROM/RAM and LED/IO port registers at top level.

Parameters:
- MEM_WAIT, 1, extra wait cycles for region 0 (memory) accesses, range 0..15.
- PORT_WAIT, 0, extra wait cycles for region 3 (port) accesses, range 0..15.

Ports:
- clk  in  1  system clock, all state changes on posedge.
- nreset  in  1  asynchronous, active-low reset.
- m0_req  in  1  CPU request, held until m0_ack.
- m0_we  in  1  1=write, 0=read.
- m0_addr  in  16  CPU address.
- m0_wdata  in  16  CPU write data.
- m0_ack  out  1  one-cycle completion pulse.
- m0_rdata  out  16  read data, valid while m0_ack=1.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata: same as m0, for the loader.
- mem_addr  out  16  latched address to memory.
- mem_wdata  out  16  latched write data, shared with the port.
- mem_re  out  1  memory read enable, held for the whole access.
- mem_we  out  1  memory write strobe, one cycle.
- mem_rdata  in  16  memory read data.
- port_re  out  1  port read enable, held for the whole access.
- port_we  out  1  port write strobe, one cycle.
- port_rdata  in  16  port read data.
- bus_err  out  1  one-cycle pulse on an unmapped access.
- grant  out  1  index of the master currently or last served.

Behaviour:
- Reset (nreset=0, asynchronous):
  - State=IDLE.
  - All acks, strobes and bus_err = 0.
  - mem_addr, mem_wdata, m0_rdata, m1_rdata = 0.
  - grant=0; last_grant=1, so m0 wins the first tie.
- Region decode on latched addr[15:14]:
  - 0: memory.
  - 3: port.
  - 1 or 2: unmapped.
- State IDLE:
  - No req: stay in IDLE.
  - One req: grant it.
  - Both req: grant the master != last_grant.
  - On grant: latch addr/we/wdata and set grant/last_grant. Load wait counter with MEM_WAIT or PORT_WAIT. Go to ACCESS, or go directly to ACK if the address is unmapped.
- State ACCESS:
  - mem_re or port_re is high for every ACCESS cycle of a read.
  - mem_we or port_we is high only in the first ACCESS cycle of a write.
  - Counter != 0: decrement and stay in ACCESS.
  - Counter == 0: capture the slave rdata into the granted master's rdata register (reads only) and go to ACK.
- State ACK:
  - Granted master's ack=1 for exactly one cycle; rdata is valid that cycle.
  - Unmapped access: bus_err=1 in this cycle and rdata=0.
  - Next state IDLE.
- Latency:
  - Region 0/3: ack asserted WAIT+2 cycles after the first req-high posedge.
  - Unmapped: ack asserted 1 cycle after grant.
  - Next grant evaluated in the IDLE cycle after ACK. The minimum request-to-request period is WAIT+3 cycles.
- A req still high in IDLE after its ack counts as a new request.
- Dropping req during ACCESS does not abort the access; it completes and ack still pulses.
- Non-granted master inputs are ignored until IDLE.
- Writes leave the rdata registers unchanged.
- Wait counter is 4 bits and never underflows.
- nreset asserted mid-access aborts immediately: no ack, strobes drop asynchronously.

Decomposition:
- Package tiny16_bus_pkg:
  - Region constants REG_MEM=2'd0, REG_PORT=2'd3.
  - State encoding IDLE/ACCESS/ACK.
  - Wait-counter width constant WAIT_BITS=4.
- Sub-module tiny16_rr_arbiter2: combinational 2-way round-robin grant from req[1:0] and last_grant; the state register stays in the parent.

Test Plan:
- CPU read, MEM_WAIT=1: m0_req with addr 0x0005, mem_rdata=0x1234 → mem_re high 2 cycles, m0_ack 3 cycles after req, m0_rdata=0x1234.
- CPU port write: addr 0xC000, wdata 0x0001 → port_we single pulse, mem_wdata=0x0001, m0_ack 2 cycles after req, no mem_we.
- Simultaneous m0/m1 reads after reset → m0 served first, then m1, then m0 again if both are still requesting; grant toggles 0,1,0.
- Unmapped read at 0x4000 by m1 → no mem_re/port_re, bus_err and m1_ack together 1 cycle after grant, m1_rdata=0.
- m0_req dropped during ACCESS (MEM_WAIT=3) → access still completes and m0_ack pulses once.
- nreset pulled low during ACCESS → strobes low immediately, no ack; after release, state IDLE and grant=0.

Source files
------------

// File: rtl/tiny16_bus_arbiter_pkg.sv
// Shared constants and types for the tiny16 bus arbiter: region codes,
// FSM state encoding and wait-counter width.
package tiny16_bus_pkg;

  localparam int DATA_W    = 16;
  localparam int WAIT_BITS = 4;

  localparam logic [1:0] REG_MEM  = 2'd0;
  localparam logic [1:0] REG_PORT = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_e;

  function automatic logic [1:0] region_of(input logic [DATA_W-1:0] addr);
    return addr[DATA_W-1 -: 2];
  endfunction

  function automatic logic is_mapped(input logic [1:0] region);
    return (region == REG_MEM) || (region == REG_PORT);
  endfunction

endpackage

// File: rtl/tiny16_bus_arbiter_if.sv
// One master's request/ack handshake on the tiny16 bus.
interface tiny16_bus_if;
  import tiny16_bus_pkg::*;

  logic              req;
  logic              we;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata
  );

endinterface

// File: rtl/tiny16_bus_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin pick; the caller keeps last_grant.
module tiny16_rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  always_comb begin
    gnt_valid = |req;
    gnt_idx   = 1'b0;
    case (req)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ~last_grant;
      default: gnt_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/tiny16_bus_arbiter.sv
// Two-master tiny16 bus arbiter: round-robin grant, region decode,
// wait-stated memory/port strobes and a one-cycle ack back to the winner.
module tiny16_bus_arbiter
  import tiny16_bus_pkg::*;
#(
  parameter int unsigned MEM_WAIT  = 1,
  parameter int unsigned PORT_WAIT = 0
) (
  input  logic              clk,
  input  logic              nreset,
  tiny16_bus_if.slave       m0,
  tiny16_bus_if.slave       m1,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              port_re,
  output logic              port_we,
  input  logic [DATA_W-1:0] port_rdata,
  output logic              bus_err,
  output logic              grant
);

  localparam logic [WAIT_BITS-1:0] MEM_WAIT_C  = WAIT_BITS'(MEM_WAIT);
  localparam logic [WAIT_BITS-1:0] PORT_WAIT_C = WAIT_BITS'(PORT_WAIT);

  state_e                state_q, state_d;
  logic                  grant_q, grant_d;
  logic                  last_grant_q, last_grant_d;
  logic                  we_q, we_d;
  logic                  first_q, first_d;
  logic [WAIT_BITS-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     rdata0_q, rdata0_d;
  logic [DATA_W-1:0]     rdata1_q, rdata1_d;

  logic                  arb_valid;
  logic                  arb_idx;
  logic                  sel_we;
  logic [DATA_W-1:0]     sel_addr;
  logic [DATA_W-1:0]     sel_wdata;
  logic [DATA_W-1:0]     slave_rdata;
  logic [1:0]            region_q;
  logic                  in_access;
  logic                  in_ack;
  logic                  is_mem;
  logic                  is_port;

  tiny16_rr_arbiter2 u_arb (
    .req        ({m1.req, m0.req}),
    .last_grant (last_grant_q),
    .gnt_valid  (arb_valid),
    .gnt_idx    (arb_idx)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      first_q      <= 1'b0;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      first_q      <= first_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  always_comb begin
    sel_addr    = arb_idx ? m1.addr  : m0.addr;
    sel_wdata   = arb_idx ? m1.wdata : m0.wdata;
    sel_we      = arb_idx ? m1.we    : m0.we;
    slave_rdata = (region_q == REG_PORT) ? port_rdata : mem_rdata;
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    first_d      = first_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;

    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          grant_d      = arb_idx;
          last_grant_d = arb_idx;
          addr_d       = sel_addr;
          wdata_d      = sel_wdata;
          we_d         = sel_we;
          first_d      = 1'b1;
          case (region_of(sel_addr))
            REG_MEM: begin
              cnt_d   = MEM_WAIT_C;
              state_d = ACCESS;
            end
            REG_PORT: begin
              cnt_d   = PORT_WAIT_C;
              state_d = ACCESS;
            end
            // Unmapped: no slave is touched, answer with an error ack.
            default: begin
              cnt_d   = '0;
              state_d = ACK;
            end
          endcase
        end
      end

      ACCESS: begin
        first_d = 1'b0;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          if (!we_q) begin
            if (grant_q) rdata1_d = slave_rdata;
            else         rdata0_d = slave_rdata;
          end
          state_d = ACK;
        end
      end

      ACK: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Strobes decode straight from flops so an async reset drops them at once.
  always_comb begin
    region_q  = region_of(addr_q);
    in_access = (state_q == ACCESS);
    in_ack    = (state_q == ACK);
    is_mem    = (region_q == REG_MEM);
    is_port   = (region_q == REG_PORT);
  end

  assign mem_re    = in_access && is_mem  && !we_q;
  assign mem_we    = in_access && is_mem  &&  we_q && first_q;
  assign port_re   = in_access && is_port && !we_q;
  assign port_we   = in_access && is_port &&  we_q && first_q;
  assign bus_err   = in_ack && !is_mapped(region_q);

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign grant     = grant_q;

  assign m0.ack    = in_ack && !grant_q;
  assign m1.ack    = in_ack &&  grant_q;
  assign m0.rdata  = bus_err ? '0 : rdata0_q;
  assign m1.rdata  = bus_err ? '0 : rdata1_q;

endmodule

// File: tb/tb_tiny16_bus_arbiter.sv
// Scoreboard bench for tiny16_bus_arbiter: directed transfers push expected
// acks into a queue, a negedge monitor pops and compares them.
module tb_tiny16_bus_arbiter;

  typedef struct {
    bit          mst;
    bit          err;
    bit          chk_rd;
    logic [15:0] rdata;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic nreset;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  exp_t a_q[$];
  exp_t b_q[$];

  tiny16_bus_if a0();
  tiny16_bus_if a1();
  tiny16_bus_if b0();
  tiny16_bus_if b1();

  logic [15:0] a_mem_addr, a_mem_wdata, a_mem_rdata, a_port_rdata;
  logic        a_mem_re, a_mem_we, a_port_re, a_port_we, a_bus_err, a_grant;
  logic [15:0] b_mem_addr, b_mem_wdata, b_mem_rdata, b_port_rdata;
  logic        b_mem_re, b_mem_we, b_port_re, b_port_we, b_bus_err, b_grant;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave models: a fixed word at 0x0005, otherwise an address-derived pattern.
  assign a_mem_rdata  = (a_mem_addr == 16'h0005) ? 16'h1234 : (a_mem_addr ^ 16'hA5A5);
  assign a_port_rdata = a_mem_addr ^ 16'h5A5A;
  assign b_mem_rdata  = b_mem_addr ^ 16'hA5A5;
  assign b_port_rdata = b_mem_addr ^ 16'h5A5A;

  tiny16_bus_arbiter #(.MEM_WAIT(1), .PORT_WAIT(0)) dut_a (
    .clk(clk), .nreset(nreset), .m0(a0), .m1(a1),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_re(a_mem_re), .mem_we(a_mem_we),
    .mem_rdata(a_mem_rdata), .port_re(a_port_re), .port_we(a_port_we),
    .port_rdata(a_port_rdata), .bus_err(a_bus_err), .grant(a_grant)
  );

  tiny16_bus_arbiter #(.MEM_WAIT(3), .PORT_WAIT(0)) dut_b (
    .clk(clk), .nreset(nreset), .m0(b0), .m1(b1),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_re(b_mem_re), .mem_we(b_mem_we),
    .mem_rdata(b_mem_rdata), .port_re(b_port_re), .port_we(b_port_we),
    .port_rdata(b_port_rdata), .bus_err(b_bus_err), .grant(b_grant)
  );

  int a_mem_re_n = 0, a_mem_we_n = 0, a_port_re_n = 0, a_port_we_n = 0, a_err_n = 0;
  int b_mem_re_n = 0, b_ack_n = 0;

  always @(posedge clk) begin
    a_mem_re_n  <= a_mem_re_n  + int'(a_mem_re);
    a_mem_we_n  <= a_mem_we_n  + int'(a_mem_we);
    a_port_re_n <= a_port_re_n + int'(a_port_re);
    a_port_we_n <= a_port_we_n + int'(a_port_we);
    a_err_n     <= a_err_n     + int'(a_bus_err);
    b_mem_re_n  <= b_mem_re_n  + int'(b_mem_re);
    b_ack_n     <= b_ack_n     + int'(b0.ack) + int'(b1.ack);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitors: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (a0.ack || a1.ack) begin
      if (a_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL a_unexpected_ack: got ack m0=%0b m1=%0b, expected none (cycle %0d)",
                 a0.ack, a1.ack, cyc);
      end else begin
        exp_t e;
        e = a_q.pop_front();
        chk("a_ack_master", {31'd0, a1.ack}, {31'd0, e.mst});
        chk("a_ack_onehot", {31'd0, a0.ack & a1.ack}, 32'd0);
        chk("a_grant", {31'd0, a_grant}, {31'd0, e.mst});
        chk("a_bus_err", {31'd0, a_bus_err}, {31'd0, e.err});
        chk("a_ack_cycle", cyc, e.cyc);
        if (e.chk_rd) chk("a_rdata", {16'd0, e.mst ? a1.rdata : a0.rdata}, {16'd0, e.rdata});
      end
    end
  end

  always @(negedge clk) begin
    if (b0.ack || b1.ack) begin
      if (b_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL b_unexpected_ack: got ack m0=%0b m1=%0b, expected none (cycle %0d)",
                 b0.ack, b1.ack, cyc);
      end else begin
        exp_t e;
        e = b_q.pop_front();
        chk("b_ack_master", {31'd0, b1.ack}, {31'd0, e.mst});
        chk("b_bus_err", {31'd0, b_bus_err}, {31'd0, e.err});
        chk("b_ack_cycle", cyc, e.cyc);
        if (e.chk_rd) chk("b_rdata", {16'd0, e.mst ? b1.rdata : b0.rdata}, {16'd0, e.rdata});
      end
    end
  end

  // Raise a request on DUT A and wait (bounded) for its ack; req stays high.
  task automatic drive(input bit m, input bit we, input logic [15:0] addr, input logic [15:0] wd);
    if (!m) begin
      a0.req = 1'b1; a0.we = we; a0.addr = addr; a0.wdata = wd;
    end else begin
      a1.req = 1'b1; a1.we = we; a1.addr = addr; a1.wdata = wd;
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((!m && a0.ack) || (m && a1.ack)) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL ack_timeout: master %0d got no ack in 40 cycles, expected one", m);
  endtask

  task automatic release_req(input bit m);
    if (!m) a0.req = 1'b0;
    else    a1.req = 1'b0;
  endtask

  task automatic push_a(input bit mst, input bit err, input bit chk_rd,
                        input logic [15:0] rd, input int at);
    exp_t e;
    e.mst = mst; e.err = err; e.chk_rd = chk_rd; e.rdata = rd; e.cyc = at;
    a_q.push_back(e);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    nreset = 1'b0;
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    int s0, s1, s2;
    exp_t eb;
    a0.req = 0; a0.we = 0; a0.addr = 0; a0.wdata = 0;
    a1.req = 0; a1.we = 0; a1.addr = 0; a1.wdata = 0;
    b0.req = 0; b0.we = 0; b0.addr = 0; b0.wdata = 0;
    b1.req = 0; b1.we = 0; b1.addr = 0; b1.wdata = 0;
    nreset = 1'b1;
    #2 nreset = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_mem_re",    {31'd0, a_mem_re},  32'd0);
    chk("rst_mem_we",    {31'd0, a_mem_we},  32'd0);
    chk("rst_port_re",   {31'd0, a_port_re}, 32'd0);
    chk("rst_port_we",   {31'd0, a_port_we}, 32'd0);
    chk("rst_bus_err",   {31'd0, a_bus_err}, 32'd0);
    chk("rst_m0_ack",    {31'd0, a0.ack},    32'd0);
    chk("rst_m1_ack",    {31'd0, a1.ack},    32'd0);
    chk("rst_grant",     {31'd0, a_grant},   32'd0);
    chk("rst_mem_addr",  {16'd0, a_mem_addr},  32'd0);
    chk("rst_mem_wdata", {16'd0, a_mem_wdata}, 32'd0);
    chk("rst_m0_rdata",  {16'd0, a0.rdata},    32'd0);
    chk("rst_m1_rdata",  {16'd0, a1.rdata},    32'd0);
    nreset = 1'b1;
    @(negedge clk);

    // CPU memory read with one wait state.
    s0 = a_mem_re_n; s1 = a_mem_we_n;
    push_a(1'b0, 1'b0, 1'b1, 16'h1234, cyc + 3);
    drive(1'b0, 1'b0, 16'h0005, 16'h0000);
    release_req(1'b0);
    repeat (2) @(negedge clk);
    chk("t1_mem_re_cycles", a_mem_re_n - s0, 32'd2);
    chk("t1_mem_we_cycles", a_mem_we_n - s1, 32'd0);
    chk("t1_mem_addr", {16'd0, a_mem_addr}, 32'h0005);

    // CPU port write: single strobe, rdata register untouched.
    s0 = a_port_we_n; s1 = a_mem_we_n; s2 = a_port_re_n;
    push_a(1'b0, 1'b0, 1'b1, 16'h1234, cyc + 2);
    drive(1'b0, 1'b1, 16'hC000, 16'h0001);
    release_req(1'b0);
    repeat (2) @(negedge clk);
    chk("t2_port_we_cycles", a_port_we_n - s0, 32'd1);
    chk("t2_mem_we_cycles",  a_mem_we_n - s1,  32'd0);
    chk("t2_port_re_cycles", a_port_re_n - s2, 32'd0);
    chk("t2_mem_wdata", {16'd0, a_mem_wdata}, 32'h0001);

    // Loader port read.
    s0 = a_port_re_n;
    push_a(1'b1, 1'b0, 1'b1, 16'h9A50, cyc + 2);
    drive(1'b1, 1'b0, 16'hC00A, 16'h0000);
    release_req(1'b1);
    repeat (2) @(negedge clk);
    chk("t2b_port_re_cycles", a_port_re_n - s0, 32'd1);

    // Both masters streaming reads from reset: grants alternate 0,1,0,1.
    pulse_reset();
    push_a(1'b0, 1'b0, 1'b1, 16'hA5B5, cyc + 3);
    push_a(1'b1, 1'b0, 1'b1, 16'hA585, cyc + 7);
    push_a(1'b0, 1'b0, 1'b1, 16'hA595, cyc + 11);
    push_a(1'b1, 1'b0, 1'b1, 16'hA5E5, cyc + 15);
    fork
      begin
        drive(1'b0, 1'b0, 16'h0010, 16'h0000);
        drive(1'b0, 1'b0, 16'h0030, 16'h0000);
        release_req(1'b0);
      end
      begin
        drive(1'b1, 1'b0, 16'h0020, 16'h0000);
        drive(1'b1, 1'b0, 16'h0040, 16'h0000);
        release_req(1'b1);
      end
    join
    repeat (2) @(negedge clk);

    // Unmapped loader read: error ack one cycle after grant, no strobes.
    s0 = a_mem_re_n; s1 = a_port_re_n; s2 = a_err_n;
    push_a(1'b1, 1'b1, 1'b1, 16'h0000, cyc + 1);
    drive(1'b1, 1'b0, 16'h4000, 16'h0000);
    release_req(1'b1);
    repeat (2) @(negedge clk);
    chk("t4_mem_re_cycles",  a_mem_re_n - s0,  32'd0);
    chk("t4_port_re_cycles", a_port_re_n - s1, 32'd0);
    chk("t4_bus_err_cycles", a_err_n - s2,     32'd1);

    // Reset mid-access: strobes drop at once, no ack, then a clean restart.
    a0.req = 1'b1; a0.we = 1'b0; a0.addr = 16'h0008;
    @(negedge clk);
    chk("t6_mem_re_in_access", {31'd0, a_mem_re}, 32'd1);
    nreset = 1'b0;
    #1;
    chk("t6_mem_re_async_drop", {31'd0, a_mem_re}, 32'd0);
    chk("t6_m0_ack_aborted",    {31'd0, a0.ack},   32'd0);
    a0.req = 1'b0;
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    chk("t6_grant_after_reset", {31'd0, a_grant},  32'd0);
    chk("t6_mem_re_after_reset", {31'd0, a_mem_re}, 32'd0);
    push_a(1'b1, 1'b0, 1'b1, 16'hA585, cyc + 3);
    drive(1'b1, 1'b0, 16'h0020, 16'h0000);
    release_req(1'b1);
    repeat (2) @(negedge clk);

    // DUT B (MEM_WAIT=3): request dropped mid-access still completes once.
    s0 = b_mem_re_n; s1 = b_ack_n;
    eb.mst = 1'b0; eb.err = 1'b0; eb.chk_rd = 1'b1; eb.rdata = 16'hA5A2; eb.cyc = cyc + 5;
    b_q.push_back(eb);
    b0.req = 1'b1; b0.we = 1'b0; b0.addr = 16'h0007;
    repeat (2) @(negedge clk);
    b0.req = 1'b0;
    repeat (10) @(negedge clk);
    chk("t5_mem_re_cycles", b_mem_re_n - s0, 32'd4);
    chk("t5_ack_count",     b_ack_n - s1,    32'd1);

    chk("a_queue_drained", a_q.size(), 32'd0);
    chk("b_queue_drained", b_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
